// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM generator and its config requesters.
package pwm_pkg;

  localparam int PWM_CNT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [PWM_CNT_W-1:0] period;
    logic [PWM_CNT_W-1:0] duty;
  } pwm_cfg_t;

endpackage

// File: rtl/pwm_generator_if.sv
// Valid/ready config channel carrying a new period/duty pair to the PWM generator.
interface pwm_generator_if
  import pwm_pkg::*;
#(
  parameter int CNT_W = PWM_CNT_W
);

  logic             cfg_valid_i;
  logic             cfg_ready_o;
  logic [CNT_W-1:0] cfg_period_i;
  logic [CNT_W-1:0] cfg_duty_i;

  modport master (
    output cfg_valid_i,
    output cfg_period_i,
    output cfg_duty_i,
    input  cfg_ready_o
  );

  modport slave (
    input  cfg_valid_i,
    input  cfg_period_i,
    input  cfg_duty_i,
    output cfg_ready_o
  );

endinterface

// File: rtl/edge_tick_detect.sv
// Turns rising edges of a clk_i-synchronous divided clock into one-cycle ticks.
module edge_tick_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic div_clk_i,
  output logic tick_now_o,
  output logic tick_o
);

  logic div_q, div_d;
  logic armed_q, armed_d;
  logic tick_q, tick_d;

  // armed_q masks the first sample after reset so a high div_clk_i is not seen as an edge
  always_comb begin
    div_d   = div_clk_i;
    armed_d = 1'b1;
    tick_d  = div_clk_i & ~div_q & armed_q;
  end

  assign tick_now_o = tick_d;
  assign tick_o     = tick_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      div_q   <= 1'b0;
      armed_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      armed_q <= armed_d;
      tick_q  <= tick_d;
    end
  end

endmodule

// File: rtl/pwm_generator.sv
// Tick-driven PWM counter with shadowed period/duty applied at period boundaries.
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int CNT_W = PWM_CNT_W
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           div_clk_i,
  input  logic           en_i,
  pwm_generator_if.slave cfg,
  output logic           tick_o,
  output logic           pwm_o,
  output logic           period_end_o
);

  logic             tick;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0] sh_period_q, sh_period_d;
  logic [CNT_W-1:0] sh_duty_q, sh_duty_d;
  logic             pending_q, pending_d;
  logic             pwm_q, pwm_d;
  logic             pend_q, pend_d;
  logic             xfer, stay_run, wrap;

  edge_tick_detect u_edge (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .div_clk_i  (div_clk_i),
    .tick_now_o (tick),
    .tick_o     (tick_o)
  );

  assign cfg.cfg_ready_o = ~pending_q;
  assign xfer            = cfg.cfg_valid_i & ~pending_q;
  assign stay_run        = (state_q == RUN) & en_i;
  assign wrap            = stay_run & tick & (cnt_q == period_q);

  assign pwm_o        = pwm_q;
  assign period_end_o = pend_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en_i)  state_d = RUN;
      RUN:     if (!en_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Leaving RUN behaves like IDLE: counter cleared and any pending shadow applied at once.
  always_comb begin
    cnt_d       = cnt_q;
    period_d    = period_q;
    duty_d      = duty_q;
    sh_period_d = sh_period_q;
    sh_duty_d   = sh_duty_q;
    pending_d   = pending_q;
    pwm_d       = 1'b0;
    pend_d      = wrap;
    if (stay_run) begin
      pwm_d = (cnt_q < duty_q);
      if (tick) cnt_d = wrap ? '0 : cnt_q + 1'b1;
      if (wrap && pending_q) begin
        period_d  = sh_period_q;
        duty_d    = sh_duty_q;
        pending_d = 1'b0;
      end
      // pending_q blocks xfer, so a transfer on the wrap tick waits for the next wrap
      if (xfer) begin
        sh_period_d = cfg.cfg_period_i;
        sh_duty_d   = cfg.cfg_duty_i;
        pending_d   = 1'b1;
      end
    end else begin
      cnt_d = '0;
      if (xfer) begin
        period_d = cfg.cfg_period_i;
        duty_d   = cfg.cfg_duty_i;
      end else if (pending_q) begin
        period_d  = sh_period_q;
        duty_d    = sh_duty_q;
        pending_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      period_q    <= '0;
      duty_q      <= '0;
      sh_period_q <= '0;
      sh_duty_q   <= '0;
      pending_q   <= 1'b0;
      pwm_q       <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      duty_q      <= duty_d;
      sh_period_q <= sh_period_d;
      sh_duty_q   <= sh_duty_d;
      pending_q   <= pending_d;
      pwm_q       <= pwm_d;
      pend_q      <= pend_d;
    end
  end

endmodule

// File: tb/tb_pwm_generator.sv
// Directed and randomized bench for pwm_generator against a position-in-period reference model.
module tb_pwm_generator;
  import pwm_pkg::*;

  localparam int W = PWM_CNT_W;

  logic clk = 1'b0;
  logic rst_ni, div_clk_i, en_i;
  logic tick_o, pwm_o, period_end_o;

  pwm_generator_if #(.CNT_W(W)) cif ();

  pwm_generator #(.CNT_W(W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .div_clk_i    (div_clk_i),
    .en_i         (en_i),
    .cfg          (cif),
    .tick_o       (tick_o),
    .pwm_o        (pwm_o),
    .period_end_o (period_end_o)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  string phase = "init";

  // reference model: position inside the current period plus active/shadow configs
  bit       m_run, m_pend, m_prev, m_armed;
  bit       e_tick, e_pwm, e_pe;
  pwm_cfg_t m_act, m_sh;
  int       m_pos;

  bit       req_on;
  pwm_cfg_t req;
  int       div_mode, div_ph;

  task automatic chk(string tag, logic obs, logic exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s/%s: got %b want %b", phase, tag, obs, exp_v);
    end
  endtask

  task automatic chk_int(string tag, int obs, int exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s/%s: got %0d want %0d", phase, tag, obs, exp_v);
    end
  endtask

  task automatic model_edge();
    bit t, x;
    if (!rst_ni) begin
      m_run = 0; m_pend = 0; m_prev = 0; m_armed = 0;
      m_act = '0; m_sh = '0; m_pos = 0;
      e_tick = 0; e_pwm = 0; e_pe = 0;
      return;
    end
    t = m_armed && (div_clk_i === 1'b1) && !m_prev;
    m_prev  = (div_clk_i === 1'b1);
    m_armed = 1;
    x = (cif.cfg_valid_i === 1'b1) && !m_pend;
    e_tick = t;
    e_pe   = 0;
    e_pwm  = 0;
    if (m_run && en_i) begin
      e_pwm = (m_pos < int'(m_act.duty));
      if (t) begin
        m_pos = (m_pos + 1) % (int'(m_act.period) + 1);
        if (m_pos == 0) begin
          e_pe = 1;
          if (m_pend) begin m_act = m_sh; m_pend = 0; end
        end
      end
      if (x) begin
        m_sh   = '{period: cif.cfg_period_i, duty: cif.cfg_duty_i};
        m_pend = 1;
      end
    end else begin
      m_pos = 0;
      if (x) m_act = '{period: cif.cfg_period_i, duty: cif.cfg_duty_i};
      else if (m_pend) begin m_act = m_sh; m_pend = 0; end
      m_run = en_i;
    end
  endtask

  task automatic step();
    bit fired;
    case (div_mode)
      0: begin div_clk_i = (div_ph >= 2); div_ph = (div_ph + 1) % 4; end
      1: div_clk_i = 1'($urandom_range(0, 1));
      default: ;
    endcase
    cif.cfg_valid_i  = req_on;
    cif.cfg_period_i = req.period;
    cif.cfg_duty_i   = req.duty;
    fired = req_on && (cif.cfg_ready_o === 1'b1);
    model_edge();
    @(posedge clk);
    #1;
    if (fired) req_on = 0;
    chk("tick_o", tick_o, e_tick);
    chk("pwm_o", pwm_o, e_pwm);
    chk("period_end_o", period_end_o, e_pe);
    chk("cfg_ready_o", cif.cfg_ready_o, !m_pend);
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic send(logic [W-1:0] p, logic [W-1:0] d);
    req    = '{period: p, duty: d};
    req_on = 1;
  endtask

  task automatic wait_sent(string tag, int limit);
    int k;
    k = 0;
    while (req_on && k < limit) begin step(); k++; end
    total++;
    assert (!req_on) else begin
      bad++;
      $error("FAIL %s/%s: request pending after %0d cycles, want accepted", phase, tag, limit);
    end
  endtask

  initial begin
    int n_hi, n_pe, pi, di;
    rst_ni = 0; en_i = 0; div_clk_i = 1; div_mode = 2; div_ph = 0;
    req_on = 0; req = '0;
    cif.cfg_valid_i = 0; cif.cfg_period_i = '0; cif.cfg_duty_i = '0;
    #1;

    phase = "reset";
    run(3);
    chk("rst_tick", tick_o, 1'b0);
    chk("rst_pwm", pwm_o, 1'b0);
    chk("rst_pe", period_end_o, 1'b0);
    chk("rst_ready", cif.cfg_ready_o, 1'b1);
    rst_ni = 1;
    step();
    chk("first_no_tick", tick_o, 1'b0);
    div_clk_i = 0; step();
    div_clk_i = 1; step();
    chk("tick_after_rise", tick_o, 1'b1);
    step();
    chk("tick_one_cycle", tick_o, 1'b0);

    phase = "basic";
    div_mode = 0; div_ph = 0;
    send(3, 2);
    wait_sent("idle_xfer", 5);
    en_i = 1;
    run(16);
    n_hi = 0; n_pe = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      n_hi += int'(pwm_o === 1'b1);
      n_pe += int'(period_end_o === 1'b1);
    end
    chk_int("high_cycles", n_hi, 16);
    chk_int("period_ends", n_pe, 2);

    phase = "cfg_run";
    run(5);
    send(3, 1);
    wait_sent("run_xfer", 20);
    chk("ready_low_pending", cif.cfg_ready_o, 1'b0);
    send(3, 0);
    step();
    chk("second_held", req_on, 1'b1);
    wait_sent("second_xfer", 40);
    run(40);
    for (int i = 0; i < 16; i++) begin step(); chk("duty0_low", pwm_o, 1'b0); end

    phase = "duty_over";
    send(3, 5);
    wait_sent("xfer", 40);
    run(40);
    for (int i = 0; i < 16; i++) begin step(); chk("duty_over_high", pwm_o, 1'b1); end

    phase = "period0";
    send(0, 1);
    wait_sent("xfer", 40);
    run(40);
    n_pe = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("p0_high", pwm_o, 1'b1);
      n_pe += int'(period_end_o === 1'b1);
    end
    chk_int("p0_every_tick", n_pe, 4);

    phase = "en_drop";
    send(3, 2);
    wait_sent("xfer", 40);
    run(20);
    div_mode = 2; div_clk_i = 0;
    run(2);
    send(5, 3);
    wait_sent("xfer", 5);
    chk("ready_low_pending", cif.cfg_ready_o, 1'b0);
    div_clk_i = 1; en_i = 0;
    step();
    chk("drop_tick", tick_o, 1'b1);
    chk("drop_no_pe", period_end_o, 1'b0);
    chk("drop_pwm", pwm_o, 1'b0);
    chk("drop_ready", cif.cfg_ready_o, 1'b1);
    en_i = 1; div_mode = 0; div_ph = 0;
    run(48);

    phase = "reset_mid";
    send(3, 1);
    wait_sent("xfer", 5);
    rst_ni = 0;
    step();
    rst_ni = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      chk("after_rst_pwm", pwm_o, 1'b0);
      chk("after_rst_ready", cif.cfg_ready_o, 1'b1);
    end

    phase = "random";
    div_mode = 1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) < 3) en_i = ~en_i;
      if (!req_on && $urandom_range(0, 15) == 0) begin
        pi = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 9));
        di = int'($urandom_range(0, pi + 2));
        if (di > 255) di = 255;
        send(W'(pi), W'(di));
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
